cla8_op_sequencer: RTL and testbench

Synchronous initiator for the gate-delay 8-bit carry-lookahead adder datapath. It accepts add requests on a valid/ready interface and drives registered, glitch-free operands into the combinational CLA. It then waits a fixed number of settle cycles to cover the cumulative NAND-gate propagation delay, captures sum and carry-out, and returns them on a valid/ready response interface. This is the clocked front end that turns the combinational CLA into a transaction-level unit for the rest of the design.

---
 rtl/cla8_pkg.sv | 19 +
 rtl/cla8_seq_checker.sv | 18 +
 rtl/cla8_op_sequencer.sv | 97 +++++++++
 tb/tb_cla8_op_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla8_pkg.sv
// Shared types and defaults for the CLA8 operation sequencer.
package cla8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } seq_state_e;

  localparam int CLA8_WIDTH          = 8;
  localparam int CLA8_SETTLE_DEFAULT = 2;
  localparam int CLA8_CNT_W          = 4;

  // Counter preload: capture happens on the edge where cnt reaches zero.
  function automatic logic [CLA8_CNT_W-1:0] settle_load(input int settle);
    return CLA8_CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/cla8_seq_checker.sv
// Behavioural reference add; flags a mismatch against the gate-level CLA result.
module cla8_seq_checker #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             mismatch
);

  logic [WIDTH:0] ref_res;

  assign ref_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign mismatch = ({cout, sum} != ref_res);

endmodule

// File: rtl/cla8_op_sequencer.sv
// Transaction front end for the combinational CLA: launch operands, wait settle, capture.
// Optional result checker built when CLA8_SEQ_CHECK_EN is defined.
module cla8_op_sequencer
  import cla8_pkg::*;
#(
  parameter int WIDTH         = CLA8_WIDTH,
  parameter int SETTLE_CYCLES = CLA8_SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic [WIDTH-1:0] cla_a,
  output logic [WIDTH-1:0] cla_b,
  output logic             cla_cin,
  input  logic [WIDTH-1:0] cla_sum,
  input  logic             cla_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             err_sticky,
  output logic             busy
);

  seq_state_e            state;
  logic [CLA8_CNT_W-1:0] cnt;
  logic                  mismatch;

`ifdef CLA8_SEQ_CHECK_EN
  cla8_seq_checker #(.WIDTH(WIDTH)) u_chk (
    .a        (cla_a),
    .b        (cla_b),
    .cin      (cla_cin),
    .sum      (cla_sum),
    .cout     (cla_cout),
    .mismatch (mismatch)
  );
`else
  assign mismatch = 1'b0;
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // cla_* only load on accept so the CLA inputs never toggle between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cla_a      <= '0;
      cla_b      <= '0;
      cla_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cla_a   <= req_a;
            cla_b   <= req_b;
            cla_cin <= req_cin;
            cnt     <= settle_load(SETTLE_CYCLES);
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_sum    <= cla_sum;
            rsp_cout   <= cla_cout;
            rsp_err    <= mismatch;
            err_sticky <= err_sticky | mismatch;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla8_op_sequencer.sv
// Scoreboard bench: two sequencers (settle 2 and 3) driving behavioural CLA stubs.
module tb_cla8_op_sequencer;

  localparam int W = 8;

`ifdef CLA8_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // settle-2 instance
  logic         req_valid, req_ready, req_cin, cla_cin, cla_cout;
  logic [W-1:0] req_a, req_b, cla_a, cla_b, cla_sum;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_err, err_sticky, busy;
  logic [W-1:0] rsp_sum;

  // settle-3 instance
  logic         req_valid3, req_ready3, req_cin3, cla_cin3, cla_cout3;
  logic [W-1:0] req_a3, req_b3, cla_a3, cla_b3, cla_sum3;
  logic         rsp_valid3, rsp_ready3, rsp_cout3, rsp_err3, err_sticky3, busy3;
  logic [W-1:0] rsp_sum3;

  exp_t q2[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // CLA stub: correct add, except a deliberate sum^1 fault for 0x10 + 0x20.
  function automatic exp_t cla_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
    exp_t         e;
    logic [W:0]   r;
    r      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.err  = 1'b0;
    if (a == 8'h10 && b == 8'h20) begin
      e.sum = e.sum ^ 8'h01;
      e.err = CHK;
    end
    return e;
  endfunction

  always_comb begin
    exp_t e2, e3;
    e2        = cla_model(cla_a, cla_b, cla_cin);
    e3        = cla_model(cla_a3, cla_b3, cla_cin3);
    cla_sum   = e2.sum;
    cla_cout  = e2.cout;
    cla_sum3  = e3.sum;
    cla_cout3 = e3.cout;
  end

  cla8_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .err_sticky(err_sticky), .busy(busy)
  );

  cla8_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_cin(req_cin3),
    .cla_a(cla_a3), .cla_b(cla_b3), .cla_cin(cla_cin3),
    .cla_sum(cla_sum3), .cla_cout(cla_cout3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_sum(rsp_sum3), .rsp_cout(rsp_cout3), .rsp_err(rsp_err3),
    .err_sticky(err_sticky3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp2_expected", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        exp_t e;
        e = q2.pop_front();
        chk("rsp2_sum", rsp_sum, e.sum);
        chk("rsp2_cout", rsp_cout, e.cout);
        chk("rsp2_err", rsp_err, e.err);
      end
    end
    if (!rst && rsp_valid3 && rsp_ready3) begin
      chk("rsp3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) begin
        exp_t e;
        e = q3.pop_front();
        chk("rsp3_sum", rsp_sum3, e.sum);
        chk("rsp3_cout", rsp_cout3, e.cout);
        chk("rsp3_err", rsp_err3, e.err);
      end
    end
  end

  task automatic send2(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        q2.push_back(cla_model(a, b, cin));
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send2_timeout", req_ready, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain2();
    rsp_ready = 1'b1;
    for (int i = 0; i < 50 && q2.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain2", q2.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_a = 0; req_b = 0; req_cin = 0; rsp_ready = 0;
    req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_cin3 = 0; rsp_ready3 = 0;
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cla_a", cla_a, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // first transaction: response visible two edges after accept
    req_valid = 1'b1; req_a = 8'h0F; req_b = 8'h01; req_cin = 1'b0;
    q2.push_back(cla_model(8'h0F, 8'h01, 1'b0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_req_ready", req_ready, 0);
    chk("t1_cla_a", cla_a, 8'h0F);
    chk("t1_valid_e1", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_e2", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_e3", rsp_valid, 1);
    chk("t1_sum", rsp_sum, 8'h10);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_valid_cleared", rsp_valid, 0);
    chk("t1_sum_held", rsp_sum, 8'h10);
    chk("t1_idle", busy, 0);

    // wrap case, rsp_ready already high before valid
    send2(8'hFF, 8'h01, 1'b1);
    drain2();
    chk("t2_cout", rsp_cout, 1);

    // backpressure: response stable, new request ignored
    rsp_ready = 1'b0;
    send2(8'h33, 8'h44, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("t3_valid_up", rsp_valid, 1);
    req_valid = 1'b1; req_a = 8'h55; req_b = 8'h01; req_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_sum", rsp_sum, 8'h77);
      chk("t3_hold_ready", req_ready, 0);
      chk("t3_hold_cla_a", cla_a, 8'h33);
    end
    rsp_ready = 1'b1;
    send2(8'h66, 8'h01, 1'b0);
    chk("t3_next_cla_a", cla_a, 8'h66);
    drain2();

    // back-to-back on settle-3 instance: one accept every 5 cycles
    begin
      int last;
      last = -1;
      req_valid3 = 1'b1;
      rsp_ready3 = 1'b1;
      for (int i = 0; i < 40; i++) begin
        req_a3   = W'(i * 37 + 5);
        req_b3   = W'(i * 91 + 200);
        req_cin3 = i[0];
        if (req_ready3) begin
          q3.push_back(cla_model(req_a3, req_b3, req_cin3));
          if (last >= 0) chk("t4_accept_period", i - last, 5);
          last = i;
        end
        @(posedge clk); #1;
      end
      req_valid3 = 1'b0;
      for (int i = 0; i < 30 && q3.size() != 0; i++) begin
        @(posedge clk); #1;
      end
      chk("t4_drain3", q3.size(), 0);
    end

    // reset during SETTLE: aborts with no response
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = 8'hA5; req_b = 8'h5A; req_cin = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_in_settle", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_cla_a", cla_a, 0);
    chk("t5_cla_cin", cla_cin, 0);
    chk("t5_rsp_sum", rsp_sum, 0);
    chk("t5_rsp_cout", rsp_cout, 0);
    chk("t5_err_sticky", err_sticky, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_no_rsp", rsp_valid, 0);
    end

    // faulty CLA result, then a clean one
    send2(8'h10, 8'h20, 1'b0);
    drain2();
    chk("t6_sticky_set", err_sticky, CHK);
    send2(8'h01, 8'h02, 1'b0);
    drain2();
    chk("t6_err_clear", rsp_err, 0);
    chk("t6_sticky_hold", err_sticky, CHK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
